rx_cmd_deframer: RTL and testbench

// Receive-side counterpart of the tx framing: pops host command packets from the rx FIFO
// (header byte + optional 2-byte payload) and presents each as one parallel {cmd, payload} word

---
 rtl/rx_cmd_deframer.sv | 106 ++++++++++
 tb/tb_rx_cmd_deframer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_deframer.sv
// Pops host command packets (header + optional 2-byte payload) from the rx FIFO and
// presents each as one {cmd, payload} word with a valid/accept handshake.
module rx_cmd_deframer #(
   parameter logic [7:0]  CMD_PAYLOAD_A = 8'h05,
   parameter logic [7:0]  CMD_PAYLOAD_B = 8'h06,
   parameter int unsigned TIMEOUT       = 65535,
   parameter int unsigned CW            = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_rdata,
   input  logic        rx_rempty,
   output logic        rx_rinc,
   input  logic        ft_busy,
   output logic [7:0]  cmd,
   output logic [15:0] payload,
   output logic        has_payload,
   output logic        cmd_valid,
   input  logic        cmd_accept,
   output logic        timeout_err
);

   // state    | meaning
   // IDLE     | waiting for a header byte
   // POP_CMD  | pop and latch header
   // GAP_CMD  | dead cycle for rempty, decode payload flag
   // WAIT_MSB | waiting for payload msb (timed)
   // POP_MSB  | pop and latch payload msb
   // GAP_MSB  | dead cycle for rempty
   // WAIT_LSB | waiting for payload lsb (timed)
   // POP_LSB  | pop and latch payload lsb
   // PRESENT  | cmd_valid held until cmd_accept
   typedef enum logic [3:0] {
      S_IDLE, S_POP_CMD, S_GAP_CMD, S_WAIT_MSB, S_POP_MSB,
      S_GAP_MSB, S_WAIT_LSB, S_POP_LSB, S_PRESENT
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tmo_cnt;
   logic          byte_rdy;
   logic          waiting;
   logic          tmo_hit;
   logic          is_pl;

   assign byte_rdy = !rx_rempty && !ft_busy;
   assign waiting  = (state == S_WAIT_MSB) || (state == S_WAIT_LSB);
   assign tmo_hit  = waiting && !byte_rdy && (tmo_cnt == CW'(TIMEOUT - 1));
   assign is_pl    = (cmd == CMD_PAYLOAD_A) || (cmd == CMD_PAYLOAD_B);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (byte_rdy) state_nxt = S_POP_CMD;
         S_POP_CMD:  state_nxt = S_GAP_CMD;
         S_GAP_CMD:  state_nxt = is_pl ? S_WAIT_MSB : S_PRESENT;
         S_WAIT_MSB: begin
            if (byte_rdy)     state_nxt = S_POP_MSB;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         S_POP_MSB:  state_nxt = S_GAP_MSB;
         S_GAP_MSB:  state_nxt = S_WAIT_LSB;
         S_WAIT_LSB: begin
            if (byte_rdy)     state_nxt = S_POP_LSB;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         S_POP_LSB:  state_nxt = S_PRESENT;
         S_PRESENT:  if (cmd_accept) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rx_rinc     = (state == S_POP_CMD) || (state == S_POP_MSB) || (state == S_POP_LSB);
      cmd_valid   = (state == S_PRESENT);
      timeout_err = tmo_hit;
   end

   // Bytes are latched in the same cycle the pop strobe is high (FIFO head is first-word-fall-through).
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd         <= '0;
         payload     <= '0;
         has_payload <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            S_POP_CMD: begin
               cmd     <= rx_rdata;
               payload <= '0;
            end
            S_GAP_CMD: has_payload <= is_pl;
            S_POP_MSB: payload[15:8] <= rx_rdata;
            S_POP_LSB: payload[7:0]  <= rx_rdata;
            default: ;
         endcase
         if (waiting && !byte_rdy && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
         else                                  tmo_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_rx_cmd_deframer.sv
// Bench for rx_cmd_deframer: FIFO model, packet scoreboard built from the byte stream,
// and directed latency/backpressure/timeout/reset checks.
module tb_rx_cmd_deframer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_rdata;
   logic        rx_rempty;
   logic        rx_rinc;
   logic        ft_busy;
   logic [7:0]  cmd;
   logic [15:0] payload;
   logic        has_payload;
   logic        cmd_valid;
   logic        cmd_accept;
   logic        timeout_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  fifo[$];
   logic [24:0] exp_q[$];
   int          exp_rd = 0;
   int          pops = 0;
   int          tmo_pulses = 0;

   always #5 clk = ~clk;

   rx_cmd_deframer #(
      .CMD_PAYLOAD_A(8'h05),
      .CMD_PAYLOAD_B(8'h06),
      .TIMEOUT(TMO),
      .CW(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_rdata(rx_rdata),
      .rx_rempty(rx_rempty),
      .rx_rinc(rx_rinc),
      .ft_busy(ft_busy),
      .cmd(cmd),
      .payload(payload),
      .has_payload(has_payload),
      .cmd_valid(cmd_valid),
      .cmd_accept(cmd_accept),
      .timeout_err(timeout_err)
   );

   // Expected presented word {cmd, payload, has_payload} for a complete packet.
   function automatic logic [24:0] pkt(input logic [7:0] h, input logic [7:0] m, input logic [7:0] l);
      logic has;
      has = (h == 8'h05) || (h == 8'h06);
      return {h, (has ? {m, l} : 16'h0000), has};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic refresh();
      rx_rempty = (fifo.size() == 0);
      if (fifo.size() != 0) rx_rdata = fifo[0];
      else                  rx_rdata = 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      refresh();
   endtask

   task automatic send(input logic [7:0] h, input logic [7:0] m, input logic [7:0] l);
      push(h);
      if ((h == 8'h05) || (h == 8'h06)) begin
         push(m);
         push(l);
      end
      exp_q.push_back(pkt(h, m, l));
   endtask

   // One clock: scoreboard at negedge, FIFO pop just after the rising edge.
   task automatic tick();
      logic r;
      r = rx_rinc;
      @(negedge clk);
      if (rx_rinc) chk("rinc_nonempty", {31'd0, rx_rempty}, 32'd0);
      if (cmd_valid) begin
         if (exp_rd < exp_q.size()) begin
            chk("pkt_word", {7'd0, cmd, payload, has_payload}, {7'd0, exp_q[exp_rd]});
            if (cmd_accept) exp_rd++;
         end else begin
            chk("unexpected_valid", {31'd0, cmd_valid}, 32'd0);
         end
      end
      if (timeout_err) tmo_pulses++;
      @(posedge clk);
      #1;
      if (r) begin
         void'(fifo.pop_front());
         pops++;
      end
      refresh();
   endtask

   task automatic wait_valid(input int max, output int cyc);
      cyc = 0;
      while (!cmd_valid && cyc < max) begin
         tick();
         cyc++;
      end
      if (!cmd_valid) chk("valid_wait_expired", {31'd0, cmd_valid}, 32'd1);
   endtask

   task automatic accept();
      cmd_accept = 1'b1;
      tick();
      cmd_accept = 1'b0;
      chk("valid_after_accept", {31'd0, cmd_valid}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int c, p0, t0, c_tmo;
      rst = 1'b1;
      ft_busy = 1'b0;
      cmd_accept = 1'b0;
      refresh();
      repeat (3) tick();
      chk("rst_cmd", {24'd0, cmd}, 32'd0);
      chk("rst_payload", {16'd0, payload}, 32'd0);
      chk("rst_has", {31'd0, has_payload}, 32'd0);
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_terr", {31'd0, timeout_err}, 32'd0);
      chk("rst_rinc", {31'd0, rx_rinc}, 32'd0);
      rst = 1'b0;
      tick();

      // single no-payload header
      p0 = pops;
      send(8'h01, 8'h00, 8'h00);
      wait_valid(10, c);
      chk("lat_nopl", c, 3);
      chk("pops_nopl", pops - p0, 1);
      chk("cmd_01", {24'd0, cmd}, 32'h01);
      chk("payload_01", {16'd0, payload}, 32'h0);
      chk("has_01", {31'd0, has_payload}, 32'd0);
      accept();

      // payload header: header, gap, wait, msb, gap, wait, lsb, present
      p0 = pops;
      send(8'h05, 8'h02, 8'hA7);
      wait_valid(20, c);
      chk("lat_pl", c, 8);
      chk("pops_pl", pops - p0, 3);
      chk("cmd_05", {24'd0, cmd}, 32'h05);
      chk("payload_05", {16'd0, payload}, 32'h02A7);
      chk("has_05", {31'd0, has_payload}, 32'd1);
      accept();

      // timeout waiting for lsb
      t0 = tmo_pulses;
      c_tmo = -1;
      push(8'h06);
      push(8'h12);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (timeout_err && c_tmo < 0) c_tmo = i + 1;
      end
      chk("tmo_cycle", c_tmo, 6 + TMO - 1);
      chk("tmo_pulse_count", tmo_pulses - t0, 1);
      chk("tmo_no_valid", {31'd0, cmd_valid}, 32'd0);
      chk("tmo_fifo_empty", {31'd0, rx_rempty}, 32'd1);
      send(8'h01, 8'h00, 8'h00);
      wait_valid(10, c);
      chk("lat_after_tmo", c, 3);
      chk("cmd_after_tmo", {24'd0, cmd}, 32'h01);
      accept();

      // backpressure with three packets queued
      send(8'h01, 8'h00, 8'h00);
      wait_valid(10, c);
      send(8'h02, 8'h00, 8'h00);
      send(8'h05, 8'hC3, 8'h3C);
      send(8'h06, 8'h12, 8'h34);
      p0 = pops;
      repeat (20) tick();
      chk("bp_pops", pops - p0, 0);
      chk("bp_cmd", {24'd0, cmd}, 32'h01);
      chk("bp_valid", {31'd0, cmd_valid}, 32'd1);
      accept();
      wait_valid(10, c);
      chk("bp_lat_02", c, 3);
      chk("bp_cmd_02", {24'd0, cmd}, 32'h02);
      accept();
      wait_valid(20, c);
      chk("bp_lat_05", c, 8);
      chk("bp_payload_05", {16'd0, payload}, 32'hC33C);
      accept();
      wait_valid(20, c);
      chk("bp_cmd_06", {24'd0, cmd}, 32'h06);
      chk("bp_payload_06", {16'd0, payload}, 32'h1234);
      chk("bp_has_06", {31'd0, has_payload}, 32'd1);
      accept();

      // ft_busy holds off the header pop
      ft_busy = 1'b1;
      send(8'h01, 8'h00, 8'h00);
      p0 = pops;
      repeat (6) tick();
      chk("busy_pops", pops - p0, 0);
      chk("busy_rinc", {31'd0, rx_rinc}, 32'd0);
      ft_busy = 1'b0;
      tick();
      chk("busy_release_rinc", {31'd0, rx_rinc}, 32'd1);
      wait_valid(10, c);
      chk("busy_lat_rest", c, 2);
      accept();

      // reset while in POP_MSB: msb byte is popped, A7 becomes a header
      push(8'h05);
      push(8'h02);
      push(8'hA7);
      repeat (4) tick();
      chk("pre_rst_rinc", {31'd0, rx_rinc}, 32'd1);
      chk("pre_rst_cmd", {24'd0, cmd}, 32'h05);
      rst = 1'b1;
      tick();
      chk("mid_rst_cmd", {24'd0, cmd}, 32'd0);
      chk("mid_rst_payload", {16'd0, payload}, 32'd0);
      chk("mid_rst_has", {31'd0, has_payload}, 32'd0);
      chk("mid_rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("mid_rst_terr", {31'd0, timeout_err}, 32'd0);
      chk("mid_rst_rinc", {31'd0, rx_rinc}, 32'd0);
      chk("mid_rst_fifo", fifo.size(), 1);
      rst = 1'b0;
      exp_q.push_back(pkt(8'hA7, 8'h00, 8'h00));
      wait_valid(10, c);
      chk("post_rst_lat", c, 3);
      chk("post_rst_cmd", {24'd0, cmd}, 32'hA7);
      chk("post_rst_has", {31'd0, has_payload}, 32'd0);
      accept();

      repeat (3) tick();
      chk("all_delivered", exp_rd, exp_q.size());
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
